mpaddsub_pipe: RTL and testbench

Parametrised, handshaked, two-stage carry-select adder/subtractor for the multi-precision datapath. Operand width, block size and sideband tag width are set by parameters. It supports add, subtract, and carry/borrow-chained variants for multi-word operations. Stage 1 computes per-block dual sums, and stage 2 resolves the inter-block carry chain. A valid/ready interface with full backpressure lets the Montgomery control FSM stream operations back-to-back at one per cycle.

---
 rtl/mp_pkg.sv | 12 +
 rtl/csel_block.sv | 15 +
 rtl/mpaddsub_pipe.sv | 133 +++++++++++++
 tb/tb_mpaddsub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: opcodes and block-count helper shared by the multi-precision add/sub pipeline
package mp_pkg;
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ADDC = 2'b10,
      OP_SUBB = 2'b11
   } op_e;
   function automatic int nblk(input int width, input int blk);
      return (width + blk - 1) / blk;
   endfunction
endpackage

// File: rtl/csel_block.sv
// csel_block: carry-select block producing both the carry-in=0 and carry-in=1 sums
// Ports: a, b (W-bit addends); sum0/carry0 (a+b), sum1/carry1 (a+b+1)
module csel_block #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum0,
   output logic         carry0,
   output logic [W-1:0] sum1,
   output logic         carry1
);
   assign {carry0, sum0} = {1'b0, a} + {1'b0, b};
   assign {carry1, sum1} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
endmodule

// File: rtl/mpaddsub_pipe.sv
// mpaddsub_pipe: two-stage handshaked carry-select adder/subtractor with chained carry/borrow
// Ports: clk; reset (async, active-low); in_valid/in_ready/in_op/in_a/in_b/in_cin/in_tag (request);
//        out_valid/out_ready/out_result/out_cout/out_tag (response, cout is borrow for subtracts)
module mpaddsub_pipe
   import mp_pkg::*;
#(
   parameter int WIDTH = 1027,
   parameter int BLK   = 64,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic [TAG_W-1:0] out_tag
);
   localparam int NB = nblk(WIDTH, BLK);
   localparam int LW = WIDTH - (NB - 1) * BLK;

   if (WIDTH < 2) begin : g_chk_width
      $error("mpaddsub_pipe: WIDTH must be at least 2");
   end
   if (BLK < 1 || BLK > WIDTH) begin : g_chk_blk
      $error("mpaddsub_pipe: BLK must lie in 1..WIDTH");
   end
   if (TAG_W < 1) begin : g_chk_tag
      $error("mpaddsub_pipe: TAG_W must be at least 1");
   end

   logic             en;
   logic             sub_n, cin0;
   logic [WIDTH-1:0] b_eff, bs0, bs1, res_n;
   logic [NB-1:0]    bk0, bk1;
   logic [NB:0]      c;
   logic             v1_q, v1_d, sub_q, sub_d, ov_q, ov_d, cout_q, cout_d;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, res_q, res_d;
   logic [NB-1:0]    k0_q, k0_d, k1_q, k1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, otag_q, otag_d;

   // One enable for the whole pipe: everything advances unless a result is stuck at the output.
   assign en       = ~ov_q | out_ready;
   assign in_ready = en;

   // Subtraction is A + ~B + c0, so the only op-dependent work is inverting B and picking c0.
   assign sub_n = (in_op == OP_SUB) | (in_op == OP_SUBB);
   assign cin0  = (in_op == OP_ADD)  ? 1'b0 :
                  (in_op == OP_SUB)  ? 1'b1 :
                  (in_op == OP_ADDC) ? in_cin : ~in_cin;
   assign b_eff = sub_n ? ~in_b : in_b;
   assign c[0]  = 1'b0;

   for (genvar i = 0; i < NB; i++) begin : g_blk
      localparam int LO = i * BLK;
      localparam int BW = (i == NB - 1) ? LW : BLK;
      localparam int HI = LO + BW - 1;
      if (i == 0) begin : g_first
         // Block 0 already knows its carry-in, so both select slots carry the same value.
         logic [BW:0] t;
         assign t          = {1'b0, in_a[HI:LO]} + {1'b0, b_eff[HI:LO]} + {{BW{1'b0}}, cin0};
         assign bs0[HI:LO] = t[BW-1:0];
         assign bs1[HI:LO] = t[BW-1:0];
         assign bk0[i]     = t[BW];
         assign bk1[i]     = t[BW];
      end else begin : g_sel
         csel_block #(.W(BW)) u_csel (
            .a      (in_a[HI:LO]),
            .b      (b_eff[HI:LO]),
            .sum0   (bs0[HI:LO]),
            .carry0 (bk0[i]),
            .sum1   (bs1[HI:LO]),
            .carry1 (bk1[i])
         );
      end
      assign c[i+1]       = c[i] ? k1_q[i] : k0_q[i];
      assign res_n[HI:LO] = c[i] ? s1_q[HI:LO] : s0_q[HI:LO];
   end

   always_comb begin
      v1_d   = en ? in_valid : v1_q;
      s0_d   = en ? bs0 : s0_q;
      s1_d   = en ? bs1 : s1_q;
      k0_d   = en ? bk0 : k0_q;
      k1_d   = en ? bk1 : k1_q;
      sub_d  = en ? sub_n : sub_q;
      tag1_d = en ? in_tag : tag1_q;
      ov_d   = en ? v1_q : ov_q;
      res_d  = en ? res_n : res_q;
      cout_d = en ? (c[NB] ^ sub_q) : cout_q;
      otag_d = en ? tag1_q : otag_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q   <= 1'b0;
         s0_q   <= '0;
         s1_q   <= '0;
         k0_q   <= '0;
         k1_q   <= '0;
         sub_q  <= 1'b0;
         tag1_q <= '0;
         ov_q   <= 1'b0;
         res_q  <= '0;
         cout_q <= 1'b0;
         otag_q <= '0;
      end else begin
         v1_q   <= v1_d;
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         k0_q   <= k0_d;
         k1_q   <= k1_d;
         sub_q  <= sub_d;
         tag1_q <= tag1_d;
         ov_q   <= ov_d;
         res_q  <= res_d;
         cout_q <= cout_d;
         otag_q <= otag_d;
      end
   end

   assign out_valid  = ov_q;
   assign out_result = res_q;
   assign out_cout   = cout_q;
   assign out_tag    = otag_q;
endmodule

// File: tb/tb_mpaddsub_pipe.sv
// tb_mpaddsub_pipe: randomized self-checking bench for mpaddsub_pipe at two geometries
module tb_mpaddsub_pipe;
   import mp_pkg::*;
   localparam int W1 = 1027, B1 = 64, W2 = 130, B2 = 32, TW = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          a_iv = 0, a_ir, a_cin = 0, a_ov, a_or = 1, a_cout;
   logic [1:0]    a_op = 0;
   logic [W1-1:0] a_a = 0, a_b = 0, a_res;
   logic [TW-1:0] a_itag = 0, a_otag;
   logic          s_iv = 0, s_ir, s_cin = 0, s_ov, s_or = 1, s_cout;
   logic [1:0]    s_op = 0;
   logic [W2-1:0] s_a = 0, s_b = 0, s_res;
   logic [TW-1:0] s_itag = 0, s_otag;

   int n_cmp = 0, n_fail = 0;

   mpaddsub_pipe #(.WIDTH(W1), .BLK(B1), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir), .in_op(a_op),
      .in_a(a_a), .in_b(a_b), .in_cin(a_cin), .in_tag(a_itag), .out_valid(a_ov),
      .out_ready(a_or), .out_result(a_res), .out_cout(a_cout), .out_tag(a_otag));

   mpaddsub_pipe #(.WIDTH(W2), .BLK(B2), .TAG_W(TW)) dut_small (
      .clk(clk), .reset(reset), .in_valid(s_iv), .in_ready(s_ir), .in_op(s_op),
      .in_a(s_a), .in_b(s_b), .in_cin(s_cin), .in_tag(s_itag), .out_valid(s_ov),
      .out_ready(s_or), .out_result(s_res), .out_cout(s_cout), .out_tag(s_otag));

   // Reference: plain integer arithmetic on n-bit unsigned operands; returns {cout/borrow, result}.
   function automatic logic [W1:0] model(int n, logic [1:0] op, logic [W1-1:0] x, logic [W1-1:0] y, logic ci);
      logic [W1+1:0] t, mask;
      logic k, sub, co;
      sub  = (op == OP_SUB) || (op == OP_SUBB);
      k    = ((op == OP_ADDC) || (op == OP_SUBB)) ? ci : 1'b0;
      mask = ({{(W1+1){1'b0}}, 1'b1} << n) - 1;
      if (sub) begin
         t  = {2'b0, x} - {2'b0, y} - {{(W1+1){1'b0}}, k};
         co = {2'b0, x} < ({2'b0, y} + {{(W1+1){1'b0}}, k});
      end else begin
         t  = {2'b0, x} + {2'b0, y} + {{(W1+1){1'b0}}, k};
         co = t[n];
      end
      return {co, t[W1-1:0] & mask[W1-1:0]};
   endfunction

   function automatic logic [W1-1:0] rnd(int n);
      logic [W1-1:0] v, m;
      int sel;
      v = '0;
      for (int i = 0; i < (W1 + 31) / 32; i++) v = (v << 32) | W1'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) v = '0;
      if (sel == 1) v = '1;
      m = '1;
      m = m >> (W1 - n);
      return v & m;
   endfunction

   function automatic int hibit(logic [W1-1:0] v);
      for (int i = W1 - 1; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   // Drives one op into an idle big DUT and samples it one and two edges later.
   task automatic big_op(input logic [1:0] op, input logic [W1-1:0] x, input logic [W1-1:0] y,
                         input logic ci, input logic [TW-1:0] tg, output logic acc, output logic v_early,
                         output logic v_late, output logic [W1-1:0] r, output logic co, output logic [TW-1:0] to);
      @(negedge clk);
      a_or = 1; a_iv = 1; a_op = op; a_a = x; a_b = y; a_cin = ci; a_itag = tg;
      #1 acc = a_ir;
      @(negedge clk);
      a_iv = 0;
      v_early = a_ov;
      @(negedge clk);
      v_late = a_ov; r = a_res; co = a_cout; to = a_otag;
   endtask

   task automatic test_reset;
      reset = 0;
      #12;
      n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", a_ov); end
      n_cmp++; if (a_res !== '0) begin n_fail++; $display("FAIL reset out_result: got nonzero, top set bit %0d want 0", hibit(a_res)); end
      n_cmp++; if (a_cout !== 1'b0) begin n_fail++; $display("FAIL reset out_cout: got %b want 0", a_cout); end
      n_cmp++; if (a_otag !== '0) begin n_fail++; $display("FAIL reset out_tag: got %h want 0", a_otag); end
      n_cmp++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", a_ir); end
      n_cmp++; if (s_ov !== 1'b0 || s_res !== '0) begin n_fail++; $display("FAIL reset small outputs: valid %b result %h want 0/0", s_ov, s_res); end
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_add_ones;
      logic acc, ve, vl, co;
      logic [W1-1:0] r, ones;
      logic [TW-1:0] to;
      ones = '1;
      big_op(OP_ADD, ones, W1'(1), 1'b0, 4'h3, acc, ve, vl, r, co, to);
      n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL add_ones accept: in_ready %b want 1", acc); end
      n_cmp++; if (ve !== 1'b0) begin n_fail++; $display("FAIL add_ones early valid: got %b want 0 after first edge", ve); end
      n_cmp++; if (vl !== 1'b1) begin n_fail++; $display("FAIL add_ones latency: out_valid %b want 1 after second edge", vl); end
      n_cmp++; if (r !== '0) begin n_fail++; $display("FAIL add_ones result: got[63:0]=%h want 0, top diff bit %0d", r[63:0], hibit(r)); end
      n_cmp++; if (co !== 1'b1) begin n_fail++; $display("FAIL add_ones cout: got %b want 1", co); end
      n_cmp++; if (to !== 4'h3) begin n_fail++; $display("FAIL add_ones tag: got %h want 3", to); end
   endtask

   task automatic test_sub;
      logic acc, ve, vl, co;
      logic [W1-1:0] r, ones, x;
      logic [TW-1:0] to;
      ones = '1;
      big_op(OP_SUB, '0, W1'(1), 1'b1, 4'h5, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== ones) begin n_fail++; $display("FAIL sub_0_1 result: got[63:0]=%h want all ones, top diff bit %0d", r[63:0], hibit(r ^ ones)); end
      n_cmp++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub_0_1 borrow: got %b want 1", co); end
      x = rnd(W1) | W1'(2);
      big_op(OP_SUB, x, x, 1'b1, 4'h6, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== '0) begin n_fail++; $display("FAIL sub_equal result: got[63:0]=%h want 0, top diff bit %0d", r[63:0], hibit(r)); end
      n_cmp++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub_equal borrow: got %b want 0", co); end
   endtask

   task automatic test_chain;
      logic acc, ve, vl, co;
      logic [W1-1:0] r, ones;
      logic [TW-1:0] to;
      ones = '1;
      big_op(OP_ADDC, ones, '0, 1'b1, 4'h1, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== '0 || co !== 1'b1) begin n_fail++; $display("FAIL addc_wrap: got cout %b result[63:0]=%h want 1/0", co, r[63:0]); end
      big_op(OP_SUBB, W1'(5), W1'(5), 1'b1, 4'h2, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== ones || co !== 1'b1) begin n_fail++; $display("FAIL subb_borrow: got borrow %b top diff bit %0d want 1/all ones", co, hibit(r ^ ones)); end
      big_op(OP_SUBB, W1'(5), W1'(5), 1'b0, 4'h2, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== '0 || co !== 1'b0) begin n_fail++; $display("FAIL subb_noborrow: got borrow %b result[63:0]=%h want 0/0", co, r[63:0]); end
      big_op(OP_ADD, W1'(2), W1'(3), 1'b1, 4'h4, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== W1'(5) || co !== 1'b0) begin n_fail++; $display("FAIL add_ignores_cin: got cout %b result[63:0]=%h want 0/5", co, r[63:0]); end
      big_op(OP_SUB, W1'(9), W1'(4), 1'b1, 4'h4, acc, ve, vl, r, co, to);
      n_cmp++; if (r !== W1'(5) || co !== 1'b0) begin n_fail++; $display("FAIL sub_ignores_cin: got borrow %b result[63:0]=%h want 0/5", co, r[63:0]); end
   endtask

   task automatic test_big_random;
      logic acc, ve, vl, co;
      logic [W1-1:0] r, x, y;
      logic [TW-1:0] to, tg;
      logic [1:0] op;
      logic ci;
      logic [W1:0] e;
      for (int i = 0; i < 40; i++) begin
         x = rnd(W1); y = rnd(W1); op = 2'($urandom); ci = 1'($urandom); tg = TW'($urandom);
         e = model(W1, op, x, y, ci);
         big_op(op, x, y, ci, tg, acc, ve, vl, r, co, to);
         n_cmp++;
         if ({co, r} !== e || to !== tg || vl !== 1'b1) begin
            n_fail++;
            $display("FAIL big_random op%0d: got cout %b tag %h res[63:0]=%h want cout %b tag %h res[63:0]=%h top diff bit %0d",
                     op, co, to, r[63:0], e[W1], tg, e[63:0], hibit(r ^ e[W1-1:0]));
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [W1-1:0] xs[8], ys[8], hold_res;
      logic [W1:0] q_exp[$], e;
      logic [TW-1:0] q_tag[$], hold_tag;
      logic stalled;
      int nsent, got, cyc;
      for (int i = 0; i < 8; i++) begin xs[i] = rnd(W1); ys[i] = rnd(W1); end
      nsent = 0; got = 0; cyc = 0; stalled = 0; hold_res = '0; hold_tag = '0;
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         if (stalled) begin
            n_cmp++;
            if (a_ov !== 1'b1 || a_res !== hold_res || a_otag !== hold_tag) begin
               n_fail++;
               $display("FAIL stall_hold: got valid %b tag %h diff bit %0d want 1 tag %h unchanged", a_ov, a_otag, hibit(a_res ^ hold_res), hold_tag);
            end
         end
         a_or = (cyc % 2 == 0);
         a_iv = (nsent < 8);
         if (nsent < 8) begin a_op = OP_ADD; a_a = xs[nsent]; a_b = ys[nsent]; a_cin = 0; a_itag = TW'(nsent); end
         #1;
         n_cmp++;
         if (a_ir !== !(a_ov && !a_or)) begin n_fail++; $display("FAIL bp_in_ready: got %b want %b (out_valid %b out_ready %b)", a_ir, !(a_ov && !a_or), a_ov, a_or); end
         stalled = a_ov && !a_or;
         hold_res = a_res; hold_tag = a_otag;
         if (a_ov && a_or) begin
            n_cmp++;
            if (q_exp.size() == 0) begin
               n_fail++; $display("FAIL bp_extra_output: got tag %h want none", a_otag);
            end else begin
               e = q_exp.pop_front();
               if (a_otag !== q_tag[0] || {a_cout, a_res} !== e) begin
                  n_fail++; $display("FAIL bp_order: got tag %h cout %b want tag %h cout %b top diff bit %0d", a_otag, a_cout, q_tag[0], e[W1], hibit(a_res ^ e[W1-1:0]));
               end
               void'(q_tag.pop_front());
            end
            got++;
         end
         if (a_iv && a_ir) begin
            q_exp.push_back(model(W1, OP_ADD, xs[nsent], ys[nsent], 1'b0));
            q_tag.push_back(TW'(nsent));
            nsent++;
         end
         cyc++;
      end
      @(negedge clk);
      a_iv = 0; a_or = 1;
      n_cmp++;
      if (got != 8 || nsent != 8) begin n_fail++; $display("FAIL bp_count: got %0d outputs from %0d sent want 8/8", got, nsent); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_inflight;
      logic acc, ve, vl, co;
      logic [W1-1:0] r, x, y;
      logic [TW-1:0] to;
      logic [W1:0] e;
      @(negedge clk);
      a_or = 1; a_iv = 1; a_op = OP_ADD; a_a = rnd(W1) | W1'(1); a_b = rnd(W1); a_itag = 4'h9;
      @(negedge clk);
      a_a = rnd(W1) | W1'(1); a_itag = 4'hA;
      @(negedge clk);
      a_iv = 0;
      reset = 0;
      #1;
      n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_inflight valid: got %b want 0", a_ov); end
      n_cmp++; if (a_res !== '0 || a_cout !== 1'b0 || a_otag !== '0) begin n_fail++; $display("FAIL rst_inflight data: got tag %h cout %b top bit %0d want all 0", a_otag, a_cout, hibit(a_res)); end
      repeat (2) @(negedge clk);
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_stale cycle %0d: out_valid %b want 0", i, a_ov); end
      end
      x = rnd(W1); y = rnd(W1);
      e = model(W1, OP_SUBB, x, y, 1'b1);
      big_op(OP_SUBB, x, y, 1'b1, 4'hC, acc, ve, vl, r, co, to);
      n_cmp++; if (ve !== 1'b0 || vl !== 1'b1) begin n_fail++; $display("FAIL rst_new_latency: valid after edges %b%b want 01", ve, vl); end
      n_cmp++; if ({co, r} !== e || to !== 4'hC) begin n_fail++; $display("FAIL rst_new_data: got tag %h cout %b want tag c cout %b top diff bit %0d", to, co, e[W1], hibit(r ^ e[W1-1:0])); end
   endtask

   task automatic test_small_random;
      localparam int N = 10000;
      logic [W1:0] q[$], e;
      logic [TW-1:0] qt[$];
      logic [W1-1:0] x, y;
      int sent, cyc, recv;
      sent = 0; cyc = 0; recv = 0;
      while ((sent < N || q.size() > 0) && cyc < 40000) begin
         @(negedge clk);
         s_or = ($urandom_range(0, 3) != 0);
         s_iv = (sent < N) && ($urandom_range(0, 4) != 0);
         x = rnd(W2); y = rnd(W2);
         s_a = W2'(x); s_b = W2'(y); s_op = 2'($urandom); s_cin = 1'($urandom); s_itag = TW'($urandom);
         #1;
         if (s_ov && s_or) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL small_extra: got unexpected output tag %h", s_otag);
            end else begin
               e = q.pop_front();
               if (s_res !== e[W2-1:0] || s_cout !== e[W1] || s_otag !== qt[0]) begin
                  n_fail++;
                  $display("FAIL small_random #%0d: got res %h cout %b tag %h want res %h cout %b tag %h", recv, s_res, s_cout, s_otag, e[W2-1:0], e[W1], qt[0]);
               end
               void'(qt.pop_front());
            end
            recv++;
         end
         if (s_iv && s_ir) begin
            q.push_back(model(W2, s_op, x, y, s_cin));
            qt.push_back(s_itag);
            sent++;
         end
         cyc++;
      end
      @(negedge clk);
      s_iv = 0;
      n_cmp++;
      if (sent != N || q.size() != 0) begin n_fail++; $display("FAIL small_drain: sent %0d pending %0d want %0d/0", sent, q.size(), N); end
   endtask

   initial begin
      test_reset();
      test_add_ones();
      test_sub();
      test_chain();
      test_big_random();
      test_back_to_back();
      test_reset_inflight();
      test_small_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
